data_bus_arbiter: RTL

//   Shares the single data-memory slave port between two masters: M0 (CPU load/store path)
//   and M1 (DMA / debug loader). Round-robin arbitration, registered request forwarding,

---
 rtl/data_bus_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter
//   Shares one data-memory slave port between two masters:
//     M0 - CPU load/store path, M1 - DMA / debug loader.
//   Round-robin arbitration, registered request forwarding, a variable-latency
//   slave handshake and a watchdog that terminates accesses the slave never acks.
//
// Handshake contract (both sides):
//   A master raises mX_req with addr/we/size/wd stable and holds them until it
//   sees mX_ack (a 1-cycle pulse, with mX_rd/mX_err valid in that same cycle).
//   In the cycle after the ack it either drops req or presents its next request.
//   On the slave side s_req is held with s_* stable until the slave returns a
//   1-cycle s_ack (s_rd valid with it). A transfer takes at least 3 cycles:
//   IDLE (arbitrate), BUSY (wait for s_ack), DONE (return the ack).
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   m0_* / m1_*       master request inputs and ack/err/rd outputs
//   s_*               registered slave request, slave ack/read data inputs
//   grant             index of the master owning the bus (valid in BUSY/DONE)
//   dbg_state         current FSM state (0 IDLE, 1 BUSY, 2 DONE)

module data_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_we,
    input  logic [1:0]        m0_size,
    input  logic [DATA_W-1:0] m0_wd,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rd,

    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_we,
    input  logic [1:0]        m1_size,
    input  logic [DATA_W-1:0] m1_wd,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rd,

    output logic              s_req,
    output logic [ADDR_W-1:0] s_addr,
    output logic              s_we,
    output logic [1:0]        s_size,
    output logic [DATA_W-1:0] s_wd,
    input  logic              s_ack,
    input  logic [DATA_W-1:0] s_rd,

    output logic              grant,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Watchdog only needs to reach TIMEOUT-1.
    localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]        r_state;
    logic              r_grant;
    logic              r_last_grant;
    logic [ADDR_W-1:0] r_s_addr;
    logic              r_s_we;
    logic [1:0]        r_s_size;
    logic [DATA_W-1:0] r_s_wd;
    logic [DATA_W-1:0] r_rd_q;
    logic              r_err_q;
    logic [WDOG_W-1:0] r_wdog;

    logic              w_pick;
    logic              w_timeout;
    logic              w_done;

    // Single requester wins outright; on a tie the master that did not win last time goes.
    assign w_pick    = (m0_req && m1_req) ? ~r_last_grant : m1_req;
    assign w_timeout = (TIMEOUT != 0) && (r_wdog == WDOG_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_s_addr     <= '0;
            r_s_we       <= 1'b0;
            r_s_size     <= 2'b00;
            r_s_wd       <= '0;
            r_rd_q       <= '0;
            r_err_q      <= 1'b0;
            r_wdog       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (m0_req || m1_req) begin
                        r_grant      <= w_pick;
                        r_last_grant <= w_pick;
                        r_s_addr     <= w_pick ? m1_addr : m0_addr;
                        r_s_we       <= w_pick ? m1_we   : m0_we;
                        r_s_size     <= w_pick ? m1_size : m0_size;
                        r_s_wd       <= w_pick ? m1_wd   : m0_wd;
                        r_state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_wdog <= r_wdog + 1'b1;
                    // A slave ack in the watchdog's last cycle still completes normally.
                    if (s_ack) begin
                        r_rd_q  <= s_rd;
                        r_err_q <= 1'b0;
                        r_state <= ST_DONE;
                    end else if (w_timeout) begin
                        r_err_q <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Requests are not sampled here; a still-high req is seen in IDLE.
                    r_wdog  <= '0;
                    r_err_q <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_done = (r_state == ST_DONE);

    assign s_req     = (r_state == ST_BUSY);
    assign s_addr    = r_s_addr;
    assign s_we      = r_s_we;
    assign s_size    = r_s_size;
    assign s_wd      = r_s_wd;
    assign grant     = r_grant;
    assign dbg_state = r_state;

    // Completion is steered only to the owner; the other master sees all zeros.
    assign m0_ack = w_done && !r_grant;
    assign m1_ack = w_done &&  r_grant;
    assign m0_err = m0_ack && r_err_q;
    assign m1_err = m1_ack && r_err_q;
    assign m0_rd  = m0_ack ? r_rd_q : '0;
    assign m1_rd  = m1_ack ? r_rd_q : '0;

endmodule
